// File: rtl/fp32_pkg.sv
// fp32_pkg
//   Shared FP32 field constants, classification flag indices, the output
//   register state type and the fp32_classify helper used by the
//   multiplier-sharing arbiter.
package fp32_pkg;

  localparam int FP_W    = 32;
  localparam int EXP_W   = 8;
  localparam int MAN_W   = 23;
  localparam int EXP_MSB = 30;
  localparam int EXP_LSB = 23;
  localparam logic [EXP_W-1:0] EXP_ALL_ONES = 8'hFF;

  // Bit positions inside the 3-bit {nan, inf, zero} flag vector.
  localparam int FLAG_NAN  = 2;
  localparam int FLAG_INF  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Zero is flagged for both signs; subnormals are not zero.
  function automatic logic [2:0] fp32_classify(input logic [FP_W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] m;
    logic [2:0]       f;
    e = x[EXP_MSB:EXP_LSB];
    m = x[MAN_W-1:0];
    f = '0;
    f[FLAG_NAN]  = (e == EXP_ALL_ONES) && (m != '0);
    f[FLAG_INF]  = (e == EXP_ALL_ONES) && (m == '0);
    f[FLAG_ZERO] = (e == '0) && (m == '0);
    return f;
  endfunction

endpackage

// File: rtl/fp32_mul_arbiter_rr.sv
// rr_arbiter
//   Round-robin arbiter. Holds the priority pointer and issues a one-hot
//   grant to the first active request at or above the pointer (with wrap).
//   Ports:
//     clk, rst   clock, synchronous active-high reset (pointer -> 0)
//     en_i       grant enable; a grant issued while enabled is an accepted
//                transfer, so the pointer advances past the winner
//     req_i      request vector
//     gnt_o      one-hot grant (all zero when disabled or no request)
//     gnt_idx_o  index of the granted requester (0 when no grant)
module rr_arbiter #(
  parameter int N = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     gnt_o,
  output logic [PTR_W-1:0] gnt_idx_o
);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;
  int               idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (en_i && !found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = PTR_W'(idx);
        found      = 1'b1;
      end
    end
  end

  // Next pointer is one past the winner, wrapping for non power-of-two N.
  always_comb begin
    ptr_d = ptr_q;
    if (found) begin
      ptr_d = (gnt_idx_o == PTR_W'(N - 1)) ? '0 : gnt_idx_o + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/fp32_mul_arbiter.sv
// fp32_mul_arbiter
//   Shares one combinational FP32 multiplier between NUM_REQ requesters
//   using round-robin arbitration. The granted requester's operands drive
//   mul_in_1/mul_in_2, mul_out is captured on the same edge into a
//   single-entry output register with valid/ready handshake, tagged with
//   the requester id and {nan, inf, zero} flags.
//   Ports:
//     clk, rst             clock, synchronous active-high reset
//     req_valid/req_ready  per-requester handshake (req_ready one-hot/zero)
//     req_a/req_b          packed operands, requester i at [32*i +: 32]
//     mul_in_1/mul_in_2    operands to the shared multiplier (0 if idle)
//     mul_out              combinational product from the multiplier
//     rsp_valid/rsp_ready  result handshake
//     rsp_data/rsp_id/rsp_flags  registered result, source id, class flags
//     op_count             accepted operation count, wraps
module fp32_mul_arbiter
  import fp32_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*FP_W-1:0] req_a,
  input  logic [NUM_REQ*FP_W-1:0] req_b,
  output logic [FP_W-1:0]         mul_in_1,
  output logic [FP_W-1:0]         mul_in_2,
  input  logic [FP_W-1:0]         mul_out,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [FP_W-1:0]         rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  output logic [2:0]              rsp_flags,
  output logic [CNT_W-1:0]        op_count
);

  localparam int PTR_W = $clog2(NUM_REQ);

  out_state_e       state_q, state_d;
  logic             can_accept, grant_en, fire;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0] gnt_idx;

  logic [FP_W-1:0]  data_q, data_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A slot is free when empty, or when the held result leaves this edge.
  assign can_accept = (state_q == OUT_EMPTY) || rsp_ready;
  // No grant may issue while reset is asserted.
  assign grant_en   = can_accept && !rst;
  assign fire       = |gnt;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .en_i      (grant_en),
    .req_i     (req_valid),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  assign req_ready = gnt;

  // One-hot grant makes an OR-reduction mux sufficient; idle drives zero.
  always_comb begin
    mul_in_1 = '0;
    mul_in_2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        mul_in_1 = mul_in_1 | req_a[FP_W*i +: FP_W];
        mul_in_2 = mul_in_2 | req_b[FP_W*i +: FP_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      OUT_EMPTY: if (fire) state_d = OUT_FULL;
      OUT_FULL:  if (rsp_ready && !fire) state_d = OUT_EMPTY;
      default:   state_d = OUT_EMPTY;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    id_d    = id_q;
    flags_d = flags_q;
    cnt_d   = cnt_q;
    if (fire) begin
      data_d  = mul_out;
      id_d    = ID_W'(gnt_idx);
      flags_d = fp32_classify(mul_out);
      cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OUT_EMPTY;
      data_q  <= '0;
      id_q    <= '0;
      flags_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      id_q    <= id_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rsp_valid = (state_q == OUT_FULL);
  assign rsp_data  = data_q;
  assign rsp_id    = id_q;
  assign rsp_flags = flags_q;
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_fp32_mul_arbiter.sv
module tb_fp32_mul_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]    mul_in_1, mul_in_2, mul_out;
  logic           rsp_valid, rsp_ready;
  logic [31:0]    rsp_data;
  logic [1:0]     rsp_id;
  logic [2:0]     rsp_flags;
  logic [15:0]    op_count;

  logic [31:0] a_op [N];
  logic [31:0] b_op [N];

  int checks   = 0;
  int failures = 0;

  // Reference model state (architectural view of the block)
  bit          m_full;
  logic [31:0] m_data;
  int          m_id;
  logic [2:0]  m_flags;
  logic [15:0] m_cnt;
  int          m_ptr;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = a_op[i];
      req_b[32*i +: 32] = b_op[i];
    end
  end

  // Reference FP32 multiply: round-to-nearest-even, subnormal inputs as zero.
  function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
    logic s, g, st;
    int ex, ey, e;
    logic [47:0] ma, mb, p;
    logic [23:0] m;
    bit xn, yn, xi, yi, xz, yz;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = (ex == 255) && (x[22:0] != 0);
    yn = (ey == 255) && (y[22:0] != 0);
    xi = (ex == 255) && (x[22:0] == 0);
    yi = (ey == 255) && (y[22:0] == 0);
    xz = (ex == 0);
    yz = (ey == 0);
    if (xn || yn || (xi && yz) || (xz && yi)) return 32'h7FC00000;
    if (xi || yi) return {s, 8'hFF, 23'h0};
    if (xz || yz) return {s, 31'h0};
    ma = {24'h0, 1'b1, x[22:0]};
    mb = {24'h0, 1'b1, y[22:0]};
    p  = ma * mb;
    e  = ex + ey - 127;
    if (p[47]) begin
      m = {1'b0, p[46:24]}; g = p[23]; st = |p[22:0]; e = e + 1;
    end else begin
      m = {1'b0, p[45:23]}; g = p[22]; st = |p[21:0];
    end
    if (g && (st || m[0])) m = m + 24'd1;
    if (m[23]) begin
      e = e + 1;
      m = '0;
    end
    return {s, e[7:0], m[22:0]};
  endfunction

  function automatic logic [2:0] ref_flags(input logic [31:0] x);
    logic [31:0] mag;
    mag = x & 32'h7FFFFFFF;
    return {mag > 32'h7F800000, mag == 32'h7F800000, mag == 32'h0};
  endfunction

  assign mul_out = fp_mul(mul_in_1, mul_in_2);

  fp32_mul_arbiter #(.NUM_REQ(N), .ID_W(2), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_in_1  (mul_in_1),
    .mul_in_2  (mul_in_2),
    .mul_out   (mul_out),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_flags (rsp_flags),
    .op_count  (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Model: who should win this cycle, from the round-robin rule.
  function automatic int model_grant();
    if (rst || (m_full && !rsp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // One clock cycle with inputs already applied; checks grant/mux before
  // the edge and the registered outputs after it. Returns the winner.
  task automatic cyc(output int g);
    logic [3:0] exp_gnt;
    #1;
    g = model_grant();
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_gnt));
    chk("mul_in_1", mul_in_1, (g >= 0) ? a_op[g] : 32'h0);
    chk("mul_in_2", mul_in_2, (g >= 0) ? b_op[g] : 32'h0);
    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = '0; m_id = 0; m_flags = '0; m_cnt = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_full  = 1;
      m_data  = fp_mul(a_op[g], b_op[g]);
      m_id    = g;
      m_flags = ref_flags(m_data);
      m_cnt   = m_cnt + 16'd1;
      m_ptr   = (g + 1) % N;
    end else if (m_full && rsp_ready) begin
      m_full = 0;
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_full));
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_id", 32'(rsp_id), m_id);
    chk("rsp_flags", 32'(rsp_flags), 32'(m_flags));
    chk("op_count", 32'(op_count), 32'(m_cnt));
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_norm();
    return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 144)), 23'($urandom)};
  endfunction

  initial begin
    int g;
    bit pend [N];
    logic [31:0] d_hold;
    m_full = 0; m_data = '0; m_id = 0; m_flags = '0; m_cnt = '0; m_ptr = 0;
    for (int i = 0; i < N; i++) begin a_op[i] = '0; b_op[i] = '0; pend[i] = 0; end
    rst = 1; req_valid = '0; rsp_ready = 1;

    // Reset
    cyc(g); cyc(g);
    chk("reset_valid", 32'(rsp_valid), 0);
    chk("reset_data", rsp_data, 0);
    chk("reset_cnt", 32'(op_count), 0);
    rst = 0;

    // Single request
    a_op[0] = 32'h3F800000; b_op[0] = 32'h40000000; req_valid = 4'b0001;
    #1 chk("single_gnt", 32'(req_ready), 32'h1);
    cyc(g);
    chk("single_valid", 32'(rsp_valid), 1);
    chk("single_data", rsp_data, 32'h40000000);
    chk("single_id", 32'(rsp_id), 0);
    chk("single_flags", 32'(rsp_flags), 0);
    chk("single_cnt", 32'(op_count), 1);

    // Contention after reset
    req_valid = '0; rst = 1; cyc(g); rst = 0;
    for (int i = 0; i < N; i++) begin a_op[i] = rand_norm(); b_op[i] = rand_norm(); end
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      cyc(g);
      chk("contend_id", 32'(rsp_id), k % 4);
      chk("contend_valid", 32'(rsp_valid), 1);
    end

    // Backpressure, then simultaneous drain and accept
    a_op[0] = 32'hBF800000; b_op[0] = 32'h40000000; req_valid = 4'b0001;
    cyc(g);
    chk("bp_data", rsp_data, 32'hC0000000);
    a_op[1] = 32'h3F800000; b_op[1] = 32'h40400000; req_valid = 4'b0010; rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      #1 chk("bp_stall_gnt", 32'(req_ready), 0);
      cyc(g);
      chk("bp_hold_data", rsp_data, 32'hC0000000);
      chk("bp_hold_valid", 32'(rsp_valid), 1);
    end
    rsp_ready = 1;
    #1 chk("bp_release_gnt", 32'(req_ready), 32'h2);
    cyc(g);
    chk("bp_new_valid", 32'(rsp_valid), 1);
    chk("bp_new_data", rsp_data, 32'h40400000);
    chk("bp_new_id", 32'(rsp_id), 1);
    req_valid = '0; cyc(g);

    // Classification flags on requester 2
    req_valid = 4'b0100; b_op[2] = 32'h3F800000;
    a_op[2] = 32'h7FC00000; cyc(g);
    chk("flag_nan", 32'(rsp_flags), 32'h4);
    a_op[2] = 32'h7F800000; cyc(g);
    chk("flag_inf", 32'(rsp_flags), 32'h2);
    chk("flag_inf_data", rsp_data, 32'h7F800000);
    a_op[2] = 32'h00000000; cyc(g);
    chk("flag_zero", 32'(rsp_flags), 32'h1);
    chk("flag_zero_data", rsp_data, 32'h0);
    chk("flag_id", 32'(rsp_id), 2);

    // Reset mid-stream with pointer at 2 and five ops done
    req_valid = '0; rst = 1; cyc(g); rst = 0;
    req_valid = 4'b0001;
    for (int k = 0; k < 4; k++) cyc(g);
    req_valid = 4'b0010; cyc(g);
    chk("mid_valid", 32'(rsp_valid), 1);
    chk("mid_cnt", 32'(op_count), 5);
    req_valid = 4'b1111; rst = 1;
    #1 chk("mid_rst_gnt", 32'(req_ready), 0);
    cyc(g);
    chk("mid_after_valid", 32'(rsp_valid), 0);
    chk("mid_after_cnt", 32'(op_count), 0);
    rst = 0;
    #1 chk("mid_first_gnt", 32'(req_ready), 32'h1);
    cyc(g);
    req_valid = '0; cyc(g);

    // Randomized traffic with operand hold and random backpressure
    for (int t = 0; t < 300; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 1) == 1) begin
          pend[i] = 1; a_op[i] = rand_norm(); b_op[i] = rand_norm();
        end
        req_valid[i] = pend[i];
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      cyc(g);
      if (g >= 0) pend[g] = 0;
    end
    req_valid = '0; rsp_ready = 1; cyc(g);

    // Counter wrap with requester 3 streaming
    rst = 1; cyc(g); rst = 0;
    a_op[3] = 32'h3F800000; b_op[3] = 32'h3F800000; req_valid = 4'b1000;
    for (int k = 0; k < 65535; k++) cyc(g);
    chk("wrap_ffff", 32'(op_count), 32'hFFFF);
    #1 chk("wrap_gnt", 32'(req_ready), 32'h8);
    cyc(g);
    chk("wrap_0000", 32'(op_count), 32'h0);
    chk("wrap_valid", 32'(rsp_valid), 1);
    chk("wrap_id", 32'(rsp_id), 3);
    a_op[0] = 32'h40000000; b_op[0] = 32'h40000000; req_valid = 4'b1001;
    #1 chk("wrap_after_gnt", 32'(req_ready), 32'h1);
    cyc(g);
    chk("wrap_after_data", rsp_data, 32'h40800000);
    req_valid = '0; cyc(g);
    d_hold = rsp_data;
    chk("idle_hold", rsp_data, 32'h40800000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp32_mul_arbiter.md
Name: fp32_mul_arbiter

Overview:
- Shares one combinational FP32 multiplier (operands `in_1`/`in_2`, result `out`) between NUM_REQ requesters.
- Arbitration is round-robin.
- The block drives the multiplier operand ports from the granted requester and samples the product in the same cycle.
- It returns the product through a single-entry output register with valid/ready backpressure, tagged with requester ID and class flags.

Parameters:
- NUM_REQ, 4, number of requesters (≥2).
- ID_W, $clog2(NUM_REQ), width of requester ID.
- CNT_W, 16, width of completed-operation counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester operand valid
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
- req_a  in  NUM_REQ*32  packed operand A; requester i at [32*i+:32]
- req_b  in  NUM_REQ*32  packed operand B
- mul_in_1  out  32  operand A to shared multiplier
- mul_in_2  out  32  operand B to shared multiplier
- mul_out  in  32  combinational product from shared multiplier
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  32  registered product
- rsp_id  out  ID_W  requester index of result
- rsp_flags  out  3  {nan, inf, zero} classification of rsp_data
- op_count  out  CNT_W  number of accepted operations, wraps

Behaviour:
- Reset values (synchronous):
  - rsp_valid=0, rsp_data=0, rsp_id=0, rsp_flags=0, op_count=0.
  - Round-robin pointer=0, so requester 0 has highest priority.
- Output-register FSM has two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- can_accept = EMPTY | (FULL & rsp_ready).
- Grant rules:
  - When can_accept, grant the first requester with req_valid=1, searching from pointer upward with wrap (pointer, pointer+1, …, NUM_REQ-1, 0, …).
  - req_ready = one-hot grant, combinational.
  - req_ready may depend on req_valid and rsp_ready. Requesters must not make req_valid depend on req_ready.
  - Operands must be held stable while valid and not accepted.
- Multiplier drive:
  - mul_in_1/mul_in_2 = operands of the granted requester.
  - Both are 0 when there is no grant.
  - mul_out is sampled at the clock edge of the grant cycle.
- Transfer: on req_valid[i] & req_ready[i] at edge N:
  - rsp_data←mul_out, rsp_id←i, rsp_flags←classify(mul_out).
  - rsp_valid=1 from cycle N+1; latency is 1 cycle.
  - Pointer←(i+1) mod NUM_REQ.
  - op_count←op_count+1, wrapping from all-ones to 0.
- Pointer updates only on an accepted grant; it does not move while idle or stalled.
- Stall: FULL & !rsp_ready → all req_ready=0, and rsp_data/rsp_id/rsp_flags hold stable.
- Simultaneous drain and accept (FULL & rsp_ready & any req_valid): the new result replaces the old in the same edge, rsp_valid stays 1, giving full throughput of 1 op/cycle.
- Drain with no request: FULL & rsp_ready & no req_valid → EMPTY.
- Classification of x, with exp=x[30:23] and man=x[22:0]:
  - nan = (exp==8'hFF) & (man!=0)
  - inf = (exp==8'hFF) & (man==0)
  - zero = (exp==0) & (man==0), for either sign
- Reset mid-operation: a held result is discarded (rsp_valid=0 next cycle), pointer and op_count return to 0, and no grant is issued in the cycle rst=1.
- With a single continuously-valid requester, it is granted every cycle while rsp_ready=1.

Decomposition:
- Shared package fp32_pkg holds:
  - Constants FP_W=32, EXP_W=8, MAN_W=23, EXP_MSB=30, EXP_LSB=23, EXP_ALL_ONES=8'hFF.
  - Flag index constants FLAG_NAN=2, FLAG_INF=1, FLAG_ZERO=0.
  - Classification function fp32_classify.
- One sub-module: rr_arbiter (parameter N). It holds the pointer register and produces the one-hot grant from a request vector and an advance strobe.
- Operand mux, output register and counter stay in fp32_mul_arbiter.
- In system instantiation, mul_in_1/mul_in_2/mul_out connect to the existing multiplier's in_1/in_2/out.

Test Plan:
- Bench drives mul_out from a reference FP32 multiply model.
- Single request: rsp_ready=1, req0 a=3F800000 b=40000000 → req_ready=4'b0001 that cycle; next cycle rsp_valid=1, rsp_data=40000000, rsp_id=0, rsp_flags=3'b000, op_count=1.
- Contention after reset: all four req_valid held high, rsp_ready=1 → grants 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0 with one result per cycle.
- Backpressure: result FULL (a=BF800000, b=40000000 → C0000000), rsp_ready=0 for 3 cycles with req1 valid → req_ready=0, rsp_data=C0000000 stable. Raise rsp_ready → drain and req1 accept on the same edge, rsp_valid never drops.
- Flags on req2:
  - a=7FC00000, b=3F800000 → flags=3'b100.
  - a=7F800000, b=3F800000 → flags=3'b010, data 7F800000.
  - a=00000000, b=3F800000 → flags=3'b001, data 00000000.
- Reset mid-stream: rsp_valid=1, pointer=2, op_count=5; assert rst one cycle → next cycle rsp_valid=0, op_count=0; with all requests valid, first grant is requester 0.
- Counter wrap: force 65536 accepted ops with req3 valid and rsp_ready=1 → op_count goes FFFF→0000 and arbitration is unaffected.
